// File: rtl/modbus_frame_tx_pkg.sv
// modbus_tx_pkg: shared states, frame byte counts and timing defaults for the response serializer.
package modbus_tx_pkg;

    typedef enum logic [2:0] {IDLE, PRE, LOAD, WAIT, GAP} tx_state_t;

    localparam logic [3:0] EXP_LEN        = 4'd5;
    localparam logic [3:0] ECHO_LEN       = 4'd8;
    localparam logic [3:0] RD_HDR_CRC_LEN = 4'd5;
    localparam logic [7:0] MAX_RD_QTY     = 8'd4;

    localparam int CLK_FREQ_DEFAULT  = 50_000_000;
    localparam int BAUD_RATE_DEFAULT = 115_200;
    localparam int BIT_CYCLES        = CLK_FREQ_DEFAULT / BAUD_RATE_DEFAULT;

endpackage

// File: rtl/modbus_frame_tx_if.sv
// modbus_frame_tx_if: byte handshake between the frame serializer and uart_byte_tx.
interface modbus_frame_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    modport master (output tx_start, output tx_data, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/modbus_frame_tx_gap_timer.sv
// modbus_gap_timer: loadable down-counter whose terminal count marks the last cycle of a delay.
module modbus_gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign tc = cnt == W'(1);
endmodule

// File: rtl/modbus_frame_tx.sv
// modbus_frame_tx: Modbus RTU response serializer feeding uart_byte_tx, followed by inter-frame silence.
// Optional build macro RS485_DE_EN adds the rs485_de driver-enable output and a one-bit turn-on delay.
module modbus_frame_tx
    import modbus_tx_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE = BAUD_RATE_DEFAULT,
    parameter int GAP_CHARS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_exp_rp_start,
    input  logic                tx_06_rp_start,
    input  logic                tx_03_04_rp_start,
    input  logic [39:0]         exception_seq,
    input  logic [63:0]         code06_response,
    input  logic [103:0]        code03_04_response,
    input  logic [7:0]          tx_quantity,
    modbus_frame_tx_if.master   uart,
    output logic                tx_busy,
    output logic                frame_done,
`ifdef RS485_DE_EN
    output logic                rs485_de,
`endif
    output logic                frame_err
);
    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int GAP_N   = GAP_CHARS * 11 * BIT_CYC;
    localparam int GW      = $clog2(GAP_N) + 1;

    tx_state_t     state;
    logic [103:0]  shreg;
    logic [3:0]    byte_cnt;
    logic          any_start, qty_bad, accept, gap_load, pre_load, tmr_tc;
    logic [103:0]  sel_vec;
    logic [3:0]    sel_len;
    logic [GW-1:0] tmr_val;

    assign any_start = tx_exp_rp_start || tx_06_rp_start || tx_03_04_rp_start;
    assign qty_bad   = !tx_exp_rp_start && !tx_06_rp_start &&
                       (tx_quantity == 8'd0 || tx_quantity > MAX_RD_QTY);
    assign accept    = state == IDLE && any_start && !qty_bad;
    assign gap_load  = state == WAIT && uart.tx_done && byte_cnt == 4'd1;
`ifdef RS485_DE_EN
    assign pre_load  = accept;
`else
    assign pre_load  = 1'b0;
`endif
    assign tmr_val   = gap_load ? GW'(GAP_N - 1) : GW'(BIT_CYC - 1);

    // Start priority exp > 06 > 03/04; vectors are left-aligned into the 104-bit shifter
    always_comb begin
        sel_vec = tx_exp_rp_start ? {exception_seq, 64'h0} :
                  tx_06_rp_start  ? {code06_response, 40'h0} : code03_04_response;
        sel_len = tx_exp_rp_start ? EXP_LEN :
                  tx_06_rp_start  ? ECHO_LEN : RD_HDR_CRC_LEN + {tx_quantity[2:0], 1'b0};
    end

    modbus_gap_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load || pre_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Frame sequencer: latch, byte-by-byte handshake, then silence before returning idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            byte_cnt      <= '0;
            uart.tx_start <= 1'b0;
            uart.tx_data  <= '0;
            tx_busy       <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
`ifdef RS485_DE_EN
            rs485_de      <= 1'b0;
`endif
        end else begin
            uart.tx_start <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= any_start && (tx_busy || qty_bad);
            case (state)
                IDLE: if (accept) begin
                    shreg    <= sel_vec;
                    byte_cnt <= sel_len;
                    tx_busy  <= 1'b1;
`ifdef RS485_DE_EN
                    rs485_de <= 1'b1;
                    state    <= PRE;
`else
                    state    <= LOAD;
`endif
                end
                PRE: if (tmr_tc) state <= LOAD;
                LOAD: begin
                    uart.tx_data  <= shreg[103:96];
                    uart.tx_start <= 1'b1;
                    state         <= WAIT;
                end
                WAIT: if (uart.tx_done) begin
                    shreg    <= {shreg[95:0], 8'h00};
                    byte_cnt <= byte_cnt - 4'd1;
                    state    <= byte_cnt == 4'd1 ? GAP : LOAD;
`ifdef RS485_DE_EN
                    if (byte_cnt == 4'd1) rs485_de <= 1'b0;
`endif
                end
                GAP: if (tmr_tc) begin
                    frame_done <= 1'b1;
                    tx_busy    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modbus_frame_tx.sv
// tb_modbus_frame_tx: randomized scoreboard bench for the Modbus response serializer.
module tb_modbus_frame_tx;
    localparam int CLK_FREQ  = 5_000_000;
    localparam int BAUD_RATE = 115_200;
    localparam int GAP_CHARS = 4;
    localparam int BITC      = CLK_FREQ / BAUD_RATE;
    localparam int GAP_N     = GAP_CHARS * 11 * BITC;
    localparam int BUDGET    = 13 * 20 + BITC + GAP_N + 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_exp_rp_start = 1'b0, tx_06_rp_start = 1'b0, tx_03_04_rp_start = 1'b0;
    logic [39:0]  exception_seq = '0;
    logic [63:0]  code06_response = '0;
    logic [103:0] code03_04_response = '0;
    logic [7:0]   tx_quantity = '0;
    logic         tx_busy, frame_done, frame_err;
`ifdef RS485_DE_EN
    logic         rs485_de;
    logic         de_prev = 1'b0;
    longint       de_rise = 0;
`endif

    modbus_frame_tx_if uart ();

    modbus_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .GAP_CHARS(GAP_CHARS)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tx_exp_rp_start    (tx_exp_rp_start),
        .tx_06_rp_start     (tx_06_rp_start),
        .tx_03_04_rp_start  (tx_03_04_rp_start),
        .exception_seq      (exception_seq),
        .code06_response    (code06_response),
        .code03_04_response (code03_04_response),
        .tx_quantity        (tx_quantity),
        .uart               (uart.master),
        .tx_busy            (tx_busy),
        .frame_done         (frame_done),
`ifdef RS485_DE_EN
        .rs485_de           (rs485_de),
`endif
        .frame_err          (frame_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int         frames_pend = 0, err_pend = 0, idx = 0;
    bit         m_busy = 1'b0, awaiting = 1'b0;
    longint     cyc = 0, last_done = 0;
    logic [7:0] cur_byte = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // reference model: a frame is the leading n bytes of the vector, most significant first
    task automatic push_frame(input logic [103:0] v, input int w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(v >> (w - 8 * (i + 1))));
        frames_pend++;
        m_busy = 1'b1;
    endtask

    task automatic issue(input bit e, input bit s6, input bit s34);
        if (m_busy) err_pend++;
        else if (e) push_frame({64'h0, exception_seq}, 40, 5);
        else if (s6) push_frame({40'h0, code06_response}, 64, 8);
        else if (tx_quantity >= 1 && tx_quantity <= 4) push_frame(code03_04_response, 104, 5 + 2 * int'(tx_quantity));
        else err_pend++;
        @(posedge clk); #1;
        tx_exp_rp_start = e; tx_06_rp_start = s6; tx_03_04_rp_start = s34;
        @(posedge clk); #1;
        tx_exp_rp_start = 0; tx_06_rp_start = 0; tx_03_04_rp_start = 0;
        chk("tx_busy after start", tx_busy, m_busy);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (m_busy && i < BUDGET) begin @(negedge clk); i++; end
        chk("frame completes within budget", m_busy, 1'b0);
        if (m_busy) begin exp_q.delete(); frames_pend = 0; m_busy = 0; idx = 0; end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_byte(input int n);
        for (int i = 0; i < BUDGET && idx < n; i++) begin @(negedge clk); #1; end
        chk("reached byte in frame", idx >= n, 1'b1);
    endtask

    // UART stand-in: acknowledge each byte after a random number of cycles
    initial begin
        uart.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (uart.tx_start) begin
                repeat ($urandom_range(1, 12)) @(posedge clk);
                #1 uart.tx_done = 1'b1;
                @(posedge clk);
                #1 uart.tx_done = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a byte, frame end or error
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (uart.tx_start) begin
                chk("tx_start expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("tx_data", uart.tx_data, exp_q.pop_front());
                chk("tx_busy at tx_start", tx_busy, 1'b1);
                if (idx > 0) chk("tx_start 2 cycles after tx_done", cyc - last_done, 2);
`ifdef RS485_DE_EN
                else chk("rs485_de lead", cyc - de_rise, BITC);
`endif
                idx++;
                cur_byte = uart.tx_data;
                awaiting = 1'b1;
            end
            if (uart.tx_done && awaiting) begin
                chk("tx_data held until tx_done", uart.tx_data, cur_byte);
                awaiting = 1'b0;
                last_done = cyc;
            end
            if (frame_done) begin
                chk("frame_done expected", frames_pend > 0, 1'b1);
                chk("bytes left at frame_done", exp_q.size(), 0);
                chk("gap length", cyc - last_done, GAP_N);
                chk("tx_busy at frame_done", tx_busy, 1'b0);
                if (frames_pend > 0) frames_pend--;
                m_busy = 1'b0;
                idx = 0;
            end
            if (frame_err) begin
                chk("frame_err expected", err_pend > 0, 1'b1);
                if (err_pend > 0) err_pend--;
            end
`ifdef RS485_DE_EN
            if (rs485_de && !de_prev) begin
                de_rise = cyc;
                chk("rs485_de rises with tx_busy", tx_busy, 1'b1);
            end
            if (!rs485_de && de_prev) chk("rs485_de drops at gap entry", cyc - last_done, 1);
`endif
        end
`ifdef RS485_DE_EN
        de_prev = rs485_de;
`endif
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset tx_start", uart.tx_start, 1'b0);
        chk("reset tx_data", uart.tx_data, 8'h00);
        chk("reset tx_busy", tx_busy, 1'b0);
        chk("reset frame_done", frame_done, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        code06_response = 64'h0106_0001_0005_1809;
        issue(0, 1, 0);
        wait_idle();

        exception_seq = 40'h01_86_02_C3_A1;
        issue(1, 0, 0);
        wait_idle();

        code03_04_response = {88'h01_04_08_53_47_74_14_20_21_04_02, 16'h5A3C};
        tx_quantity = 8'd4;
        issue(0, 0, 1);
        wait_idle();
        tx_quantity = 8'd1;
        issue(0, 0, 1);
        wait_idle();

        code06_response = 64'h1106_0203_0405_A1B2;
        issue(0, 1, 0);
        wait_byte(3);
        code06_response = 64'hFFEE_DDCC_BBAA_9988;
        issue(0, 1, 0);
        wait_idle();

        tx_quantity = 8'd0;
        issue(0, 0, 1);
        tx_quantity = 8'd5;
        issue(0, 0, 1);
        wait_idle();

        exception_seq = 40'h07_83_04_11_22;
        issue(1, 1, 0);
        wait_idle();

        code06_response = 64'h0206_0010_00FF_C0DE;
        issue(0, 1, 0);
        wait_byte(2);
        rst_n = 1'b0;
        #1;
        chk("async reset tx_start", uart.tx_start, 1'b0);
        chk("async reset tx_busy", tx_busy, 1'b0);
        exp_q.delete(); frames_pend = 0; m_busy = 0; idx = 0; awaiting = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(0, 1, 0);
        wait_idle();

        for (int t = 0; t < 8; t++) begin
            exception_seq = {$urandom, 8'($urandom)};
            code06_response = {$urandom, $urandom};
            code03_04_response = {$urandom, $urandom, $urandom, 8'($urandom)};
            tx_quantity = 8'($urandom_range(0, 5));
            k = $urandom_range(1, 7);
            issue(k[2], k[1], k[0]);
            wait_idle();
        end

        repeat (50) @(negedge clk);
        chk("pending frame_err at end", err_pend, 0);
        chk("pending bytes at end", exp_q.size(), 0);
        chk("pending frames at end", frames_pend, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
